// File: rtl/bin_to_bcd_seq_if.sv
// Start/done handshake bundle for the sequential binary-to-BCD converter.
// The requester uses the master modport; the converter uses the slave modport.
interface bin_to_bcd_seq_if #(
  parameter int BIT    = 9,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIT-1:0]        number;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   digits;
  logic                  overflow;
  logic [DIGITS-1:0]     blank;

  modport master (
    output start, number,
    input  busy, done, digits, overflow, blank
  );

  modport slave (
    input  start, number,
    output busy, done, digits, overflow, blank
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Double-dabble binary-to-BCD converter, one input bit per clock.
// Results are registered on the final shift, with overflow saturation and leading-zero flags.
module bin_to_bcd_seq #(
  parameter int BIT    = 9,
  parameter int DIGITS = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  bin_to_bcd_seq_if.slave bus
);
  localparam int AW = 4 * DIGITS;
  localparam int CW = $clog2(BIT + 1);
  localparam logic [CW-1:0]     CNT_LOAD  = CW'(BIT);
  localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
  localparam logic [AW-1:0]     ALL_NINE  = {DIGITS{4'h9}};
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [BIT-1:0]    s_q, s_d;
  logic [AW-1:0]     a_q, a_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [AW-1:0]     digits_q, digits_d;
  logic              overflow_q, overflow_d;
  logic [DIGITS-1:0] blank_q, blank_d;

  logic [AW-1:0]     a_adj_s;
  logic [AW-1:0]     a_sh_s;
  logic [BIT-1:0]    s_sh_s;
  logic              carry_s;

  function automatic logic [AW-1:0] add3(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = a;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = a[4*i +: 4];
      end
    end
    return r;
  endfunction

  // A digit is blanked while it and every more significant digit are zero.
  function automatic logic [DIGITS-1:0] blank_of(input logic [AW-1:0] d);
    logic [DIGITS-1:0] b;
    logic              zero_run;
    b        = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (d[4*i +: 4] == 4'd0);
      b[i]     = zero_run;
    end
    return b;
  endfunction

  assign a_adj_s                    = add3(a_q);
  assign {carry_s, a_sh_s, s_sh_s}  = {a_adj_s, s_q, 1'b0};

  // Next-state, datapath and result-register logic.
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    a_d        = a_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    digits_d   = digits_q;
    overflow_d = overflow_q;
    blank_d    = blank_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          s_d     = bus.number;
          a_d     = '0;
          cnt_d   = CNT_LOAD;
          ovf_d   = 1'b0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        s_d   = s_sh_s;
        a_d   = a_sh_s;
        ovf_d = ovf_q | carry_s;
        cnt_d = cnt_q - CNT_ONE;
        // The last shift publishes the result using the sticky flag including this carry.
        if (cnt_q == CNT_ONE) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          overflow_d = ovf_q | carry_s;
          digits_d   = (ovf_q | carry_s) ? ALL_NINE : a_sh_s;
          blank_d    = blank_of(digits_d);
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s_q        <= '0;
      a_q        <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
      blank_q    <= BLANK_RST;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      a_q        <= a_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      digits_q   <= digits_d;
      overflow_q <= overflow_d;
      blank_q    <= blank_d;
    end
  end

  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = done_q;
  assign bus.digits   = digits_q;
  assign bus.overflow = overflow_q;
  assign bus.blank    = blank_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench: two converter instances (9/3 and 8/2) checked against a decimal
// reference model built from division and powers of ten.
module tb_bin_to_bcd_seq;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  bin_to_bcd_seq_if #(.BIT(9), .DIGITS(3)) if9 ();
  bin_to_bcd_seq_if #(.BIT(8), .DIGITS(2)) if8 ();

  bin_to_bcd_seq #(.BIT(9), .DIGITS(3)) dut9 (.clk(clk), .rst_n(rst_n), .bus(if9));
  bin_to_bcd_seq #(.BIT(8), .DIGITS(2)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  always #5 clk = ~clk;

  function automatic longint p10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [39:0] m_digits(input longint v, input int d);
    logic [39:0] r;
    longint      x;
    r = '0;
    x = v;
    for (int i = 0; i < d; i++) begin
      if (v >= p10(d)) begin
        r[4*i +: 4] = 4'h9;
      end else begin
        r[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  function automatic logic [9:0] m_blank(input longint v, input int d);
    logic [9:0] b;
    b = '0;
    if (v < p10(d)) begin
      for (int i = 1; i < d; i++) b[i] = (v < p10(i));
    end
    return b;
  endfunction

  task automatic conv9(input int v, output int lat, output logic b0, output logic [11:0] d,
                       output logic ov, output logic [2:0] bl);
    bit got;
    @(negedge clk);
    if9.start  = 1'b1;
    if9.number = v[8:0];
    @(posedge clk);
    #1;
    if9.start = 1'b0;
    b0  = if9.busy;
    lat = -1;
    got = 1'b0;
    for (int k = 1; k <= 30 && !got; k++) begin
      @(posedge clk);
      #1;
      if (if9.done === 1'b1) begin
        lat = k;
        got = 1'b1;
      end
    end
    d  = if9.digits;
    ov = if9.overflow;
    bl = if9.blank;
  endtask

  task automatic conv8(input int v, output int lat, output logic [7:0] d,
                       output logic ov, output logic [1:0] bl);
    bit got;
    @(negedge clk);
    if8.start  = 1'b1;
    if8.number = v[7:0];
    @(posedge clk);
    #1;
    if8.start = 1'b0;
    lat = -1;
    got = 1'b0;
    for (int k = 1; k <= 30 && !got; k++) begin
      @(posedge clk);
      #1;
      if (if8.done === 1'b1) begin
        lat = k;
        got = 1'b1;
      end
    end
    d  = if8.digits;
    ov = if8.overflow;
    bl = if8.blank;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks += 7;
    if (if9.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", if9.busy); end
    if (if9.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", if9.done); end
    if (if9.digits !== 12'h000) begin failures++; $display("FAIL rst_digits got=%h exp=000", if9.digits); end
    if (if9.overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", if9.overflow); end
    if (if9.blank !== 3'b110) begin failures++; $display("FAIL rst_blank got=%b exp=110", if9.blank); end
    if (if8.blank !== 2'b10) begin failures++; $display("FAIL rst_blank8 got=%b exp=10", if8.blank); end
    if (if8.digits !== 8'h00) begin failures++; $display("FAIL rst_digits8 got=%h exp=00", if8.digits); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_conv9();
    int          vals[$];
    int          lat;
    logic        b0, ov;
    logic [11:0] d;
    logic [2:0]  bl;
    logic [39:0] ed;
    logic [9:0]  eb;
    vals = '{0, 511, 99, 7, 100, 10, 9, 500};
    for (int i = 0; i < 20; i++) vals.push_back(int'($urandom_range(511, 0)));
    foreach (vals[n]) begin
      conv9(vals[n], lat, b0, d, ov, bl);
      ed = m_digits(longint'(vals[n]), 3);
      eb = m_blank(longint'(vals[n]), 3);
      checks += 5;
      if (lat !== 9) begin failures++; $display("FAIL lat9 v=%0d got=%0d exp=9", vals[n], lat); end
      if (b0 !== 1'b1) begin failures++; $display("FAIL busy9 v=%0d got=%b exp=1", vals[n], b0); end
      if (d !== ed[11:0]) begin failures++; $display("FAIL digits9 v=%0d got=%h exp=%h", vals[n], d, ed[11:0]); end
      if (ov !== 1'b0) begin failures++; $display("FAIL ovf9 v=%0d got=%b exp=0", vals[n], ov); end
      if (bl !== eb[2:0]) begin failures++; $display("FAIL blank9 v=%0d got=%b exp=%b", vals[n], bl, eb[2:0]); end
    end
  endtask

  task automatic test_conv8();
    int          vals[$];
    int          lat;
    logic        ov, eo;
    logic [7:0]  d;
    logic [1:0]  bl;
    logic [39:0] ed;
    logic [9:0]  eb;
    vals = '{255, 99, 100, 0, 9, 10};
    for (int i = 0; i < 12; i++) vals.push_back(int'($urandom_range(255, 0)));
    foreach (vals[n]) begin
      conv8(vals[n], lat, d, ov, bl);
      ed = m_digits(longint'(vals[n]), 2);
      eb = m_blank(longint'(vals[n]), 2);
      eo = (longint'(vals[n]) >= p10(2));
      checks += 4;
      if (lat !== 8) begin failures++; $display("FAIL lat8 v=%0d got=%0d exp=8", vals[n], lat); end
      if (d !== ed[7:0]) begin failures++; $display("FAIL digits8 v=%0d got=%h exp=%h", vals[n], d, ed[7:0]); end
      if (ov !== eo) begin failures++; $display("FAIL ovf8 v=%0d got=%b exp=%b", vals[n], ov, eo); end
      if (bl !== eb[1:0]) begin failures++; $display("FAIL blank8 v=%0d got=%b exp=%b", vals[n], bl, eb[1:0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_q[$];
    logic        exp_done, exp_busy;
    exp_q = '{12'h123, 12'h400, 12'h009};
    @(negedge clk);
    if9.start  = 1'b1;
    if9.number = 9'd123;
    for (int k = 0; k < 35; k++) begin
      @(posedge clk);
      #1;
      if (k == 0)  if9.number = 9'd400;
      if (k == 10) if9.number = 9'd9;
      if (k == 20) if9.start  = 1'b0;
      exp_done = (k == 9) || (k == 19) || (k == 29);
      exp_busy = (k < 29) && (k % 10 != 9);
      checks += 2;
      if (if9.done !== exp_done) begin failures++; $display("FAIL b2b_done k=%0d got=%b exp=%b", k, if9.done, exp_done); end
      if (if9.busy !== exp_busy) begin failures++; $display("FAIL b2b_busy k=%0d got=%b exp=%b", k, if9.busy, exp_busy); end
      if (exp_done && exp_q.size() > 0) begin
        checks++;
        if (if9.digits !== exp_q[0]) begin failures++; $display("FAIL b2b_digits k=%0d got=%h exp=%h", k, if9.digits, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic test_busy_ignore();
    int dones;
    dones = 0;
    @(negedge clk);
    if9.start  = 1'b1;
    if9.number = 9'd356;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) if9.start = 1'b0;
      if (k == 3) begin if9.start = 1'b1; if9.number = 9'd200; end
      if (k == 4) if9.start = 1'b0;
      if (if9.done === 1'b1) begin
        dones++;
        checks += 2;
        if (k != 9) begin failures++; $display("FAIL ign_when k=%0d exp=9", k); end
        if (if9.digits !== 12'h356) begin failures++; $display("FAIL ign_digits got=%h exp=356", if9.digits); end
      end
    end
    checks++;
    if (dones != 1) begin failures++; $display("FAIL ign_count got=%0d exp=1", dones); end
  endtask

  task automatic test_reset_mid();
    int          lat, dones;
    logic        b0, ov;
    logic [11:0] d;
    logic [2:0]  bl;
    @(negedge clk);
    if9.start  = 1'b1;
    if9.number = 9'd300;
    @(posedge clk);
    #1;
    if9.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (if9.busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", if9.busy); end
    if (if9.done !== 1'b0) begin failures++; $display("FAIL mid_done got=%b exp=0", if9.done); end
    if (if9.digits !== 12'h000) begin failures++; $display("FAIL mid_digits got=%h exp=000", if9.digits); end
    if (if9.blank !== 3'b110) begin failures++; $display("FAIL mid_blank got=%b exp=110", if9.blank); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (if9.done === 1'b1 || if9.busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin failures++; $display("FAIL mid_nodone got=%0d exp=0", dones); end
    conv9(42, lat, b0, d, ov, bl);
    checks += 3;
    if (lat !== 9) begin failures++; $display("FAIL mid42_lat got=%0d exp=9", lat); end
    if (d !== 12'h042) begin failures++; $display("FAIL mid42_digits got=%h exp=042", d); end
    if (bl !== 3'b100) begin failures++; $display("FAIL mid42_blank got=%b exp=100", bl); end
  endtask

  initial begin
    clk        = 1'b0;
    checks     = 0;
    failures   = 0;
    if9.start  = 1'b0;
    if9.number = '0;
    if8.start  = 1'b0;
    if8.number = '0;
    test_reset();
    test_conv9();
    test_conv8();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
